// File: rtl/sc_road_scroll_scheduler_if.sv
// rtl/sc_road_scroll_scheduler_if.sv - strobe bus from the scroll scheduler to the road shift-register bank
interface sc_road_scroll_scheduler_if;
  logic       clear_OutLow;        // clear all road rows, active-low strobe
  logic       load0_OutLow;        // load an empty row into the top, active-low strobe
  logic       load1_OutLow;        // load an obstacle row into the top, active-low strobe
  logic [1:0] shiftselection_Out;  // 2'b11 hold, 2'b01 shift down one row

  // Scheduler side drives the strobes
  modport master (
    output clear_OutLow,
    output load0_OutLow,
    output load1_OutLow,
    output shiftselection_Out
  );

  // Road datapath side consumes them
  modport slave (
    input clear_OutLow,
    input load0_OutLow,
    input load1_OutLow,
    input shiftselection_Out
  );
endinterface

// File: rtl/sc_road_scroll_scheduler.sv
// rtl/sc_road_scroll_scheduler.sv - Road-Fighter scroll timer, spawn, collision, lives and level sequencer
module sc_road_scroll_scheduler #(
  parameter int BASE_PERIOD    = 1000000,
  parameter int PERIOD_STEP    = 100000,
  parameter int MAX_LEVEL      = 7,
  parameter int ROWS_PER_LEVEL = 16,
  parameter int SPAWN_GAP      = 4,
  parameter int LIVES          = 3,
  parameter int HIT_HOLD       = 25000000
) (
  input  logic                              SC_STATEMACHINEPOINT_CLOCK_50,
  input  logic                              SC_STATEMACHINEPOINT_RESET_InHigh,
  input  logic                              SC_STATEMACHINEPOINT_startButton_InLow,
  input  logic                              SC_STATEMACHINEPOINT_pauseButton_InLow,
  input  logic                              SC_STATEMACHINEPOINT_bottomsidecomparator_InLow,
  sc_road_scroll_scheduler_if.master        road_o,
  output logic [2:0]                        level_Out,
  output logic [1:0]                        lives_Out,
  output logic                              gameover_Out
);

  localparam int PW = $clog2(BASE_PERIOD + 1);
  localparam int SW = $clog2(ROWS_PER_LEVEL + 1);
  localparam int GW = $clog2(SPAWN_GAP + 1);
  localparam int HW = $clog2(HIT_HOLD + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_RUN, S_PAUSE, S_SHIFT,
    S_LOAD, S_CHECK, S_HIT, S_HIT_WAIT, S_GAMEOVER
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] scroll_q, scroll_d;
  logic [GW-1:0] spawn_q, spawn_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [2:0]    level_q, level_d;
  logic [1:0]    lives_q, lives_d;
  logic          start_prev_q, pause_prev_q;
  logic          start_edge, pause_edge;
  logic [PW-1:0] period_m1;
  logic          clear_n, load0_n, load1_n, gameover;
  logic [1:0]    shift_sel;

  // Buttons are already synchronous; a press is a 1 -> 0 step between samples
  assign start_edge = start_prev_q & ~SC_STATEMACHINEPOINT_startButton_InLow;
  assign pause_edge = pause_prev_q & ~SC_STATEMACHINEPOINT_pauseButton_InLow;

  // Scroll period shrinks linearly with level; terminal count is period-1
  assign period_m1 = PW'(BASE_PERIOD - 1) - PW'(PERIOD_STEP) * PW'(level_q);

  // State, counters, game registers and button history
  always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
    if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      scroll_q     <= '0;
      spawn_q      <= '0;
      hold_q       <= '0;
      level_q      <= '0;
      lives_q      <= 2'(LIVES);
      start_prev_q <= 1'b1;
      pause_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      scroll_q     <= scroll_d;
      spawn_q      <= spawn_d;
      hold_q       <= hold_d;
      level_q      <= level_d;
      lives_q      <= lives_d;
      start_prev_q <= SC_STATEMACHINEPOINT_startButton_InLow;
      pause_prev_q <= SC_STATEMACHINEPOINT_pauseButton_InLow;
    end
  end

  // Next-state/counter updates and Moore decode of the strobes
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    scroll_d  = scroll_q;
    spawn_d   = spawn_q;
    hold_d    = hold_q;
    level_d   = level_q;
    lives_d   = lives_q;
    clear_n   = 1'b1;
    load0_n   = 1'b1;
    load1_n   = 1'b1;
    shift_sel = 2'b11;
    gameover  = 1'b0;

    case (state_q)
      S_IDLE, S_GAMEOVER: begin
        gameover = (state_q == S_GAMEOVER);
        // New game: the reload happens on the way into CLEAR
        if (start_edge) begin
          state_d  = S_CLEAR;
          lives_d  = 2'(LIVES);
          level_d  = '0;
          presc_d  = '0;
          scroll_d = '0;
          spawn_d  = '0;
          hold_d   = '0;
        end
      end
      S_CLEAR: begin
        clear_n = 1'b0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (pause_edge) begin
          state_d = S_PAUSE;
        end else if (presc_q == period_m1) begin
          presc_d = '0;
          state_d = S_SHIFT;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      S_PAUSE: begin
        if (pause_edge) state_d = S_RUN;
      end
      S_SHIFT: begin
        shift_sel = 2'b01;
        scroll_d  = scroll_q + 1'b1;
        spawn_d   = spawn_q + 1'b1;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        if (spawn_q == GW'(SPAWN_GAP)) begin
          load1_n = 1'b0;
          spawn_d = '0;
        end else begin
          load0_n = 1'b0;
        end
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (scroll_q == SW'(ROWS_PER_LEVEL)) begin
          scroll_d = '0;
          if (level_q < 3'(MAX_LEVEL)) level_d = level_q + 1'b1;
        end
        state_d = SC_STATEMACHINEPOINT_bottomsidecomparator_InLow ? S_RUN : S_HIT;
      end
      S_HIT: begin
        lives_d = lives_q - 1'b1;
        if (lives_q == 2'd1) begin
          state_d = S_GAMEOVER;
        end else begin
          hold_d  = '0;
          state_d = S_HIT_WAIT;
        end
      end
      S_HIT_WAIT: begin
        // Recovery CLEAR keeps lives, level and spawn phase; only the timer restarts
        if (hold_q == HW'(HIT_HOLD - 1)) begin
          presc_d = '0;
          state_d = S_CLEAR;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign road_o.clear_OutLow       = clear_n;
  assign road_o.load0_OutLow       = load0_n;
  assign road_o.load1_OutLow       = load1_n;
  assign road_o.shiftselection_Out = shift_sel;
  assign level_Out                 = level_q;
  assign lives_Out                 = lives_q;
  assign gameover_Out              = gameover;

endmodule

// File: tb/tb_sc_road_scroll_scheduler.sv
// tb/tb_sc_road_scroll_scheduler.sv - directed self-checking bench for sc_road_scroll_scheduler
module tb_sc_road_scroll_scheduler;
  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       start_n = 1'b1;
  logic       pause_n = 1'b1;
  logic       cmp_n   = 1'b1;
  logic [2:0] level;
  logic [1:0] lives;
  logic       gameover;

  int n_cmp = 0;
  int n_bad = 0;
  int viol  = 0;
  logic prev_shift = 1'b0;

  sc_road_scroll_scheduler_if road ();

  sc_road_scroll_scheduler #(
    .BASE_PERIOD(10), .PERIOD_STEP(2), .MAX_LEVEL(3), .ROWS_PER_LEVEL(4),
    .SPAWN_GAP(3), .LIVES(2), .HIT_HOLD(5)
  ) dut (
    .SC_STATEMACHINEPOINT_CLOCK_50(clk),
    .SC_STATEMACHINEPOINT_RESET_InHigh(rst),
    .SC_STATEMACHINEPOINT_startButton_InLow(start_n),
    .SC_STATEMACHINEPOINT_pauseButton_InLow(pause_n),
    .SC_STATEMACHINEPOINT_bottomsidecomparator_InLow(cmp_n),
    .road_o(road),
    .level_Out(level),
    .lives_Out(lives),
    .gameover_Out(gameover)
  );

  always #5 clk = ~clk;

  // Load strobes: never both at once, and only right after a shift cycle
  always @(negedge clk) begin
    if (!road.load0_OutLow && !road.load1_OutLow) viol++;
    if ((!road.load0_OutLow || !road.load1_OutLow) && !prev_shift) viol++;
    prev_shift = (road.shiftselection_Out == 2'b01);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  function automatic bit idle_now();
    return road.clear_OutLow && road.load0_OutLow && road.load1_OutLow &&
           (road.shiftselection_Out == 2'b11);
  endfunction

  task automatic wait_shift(input int budget, output int n, output bit to);
    n  = 0;
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      step();
      n++;
      if (road.shiftselection_Out == 2'b01) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  // Leaves the bench at the CLEAR sample with start still held low
  task automatic reset_start();
    start_n = 1'b1; pause_n = 1'b1; cmp_n = 1'b1;
    rst = 1'b1; step(); rst = 1'b0; step();
    start_n = 1'b0; step();
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step();
    n_cmp++; if (road.clear_OutLow !== 1'b1) begin n_bad++; $display("FAIL reset_clear got %b want 1", road.clear_OutLow); end
    n_cmp++; if (road.load0_OutLow !== 1'b1) begin n_bad++; $display("FAIL reset_load0 got %b want 1", road.load0_OutLow); end
    n_cmp++; if (road.load1_OutLow !== 1'b1) begin n_bad++; $display("FAIL reset_load1 got %b want 1", road.load1_OutLow); end
    n_cmp++; if (road.shiftselection_Out !== 2'b11) begin n_bad++; $display("FAIL reset_shift got %b want 11", road.shiftselection_Out); end
    n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL reset_level got %0d want 0", level); end
    n_cmp++; if (lives !== 2'd2) begin n_bad++; $display("FAIL reset_lives got %0d want 2", lives); end
    n_cmp++; if (gameover !== 1'b0) begin n_bad++; $display("FAIL reset_gameover got %b want 0", gameover); end
    rst = 1'b0; step(); step();
    n_cmp++; if (!idle_now()) begin n_bad++; $display("FAIL idle_after_release got non-idle want idle"); end
  endtask

  task automatic test_start();
    int n; bit to;
    start_n = 1'b0; step();
    n_cmp++; if (road.clear_OutLow !== 1'b0) begin n_bad++; $display("FAIL start_clear got %b want 0", road.clear_OutLow); end
    step();
    n_cmp++; if (road.clear_OutLow !== 1'b1) begin n_bad++; $display("FAIL clear_one_cycle got %b want 1", road.clear_OutLow); end
    wait_shift(40, n, to);
    n_cmp++; if (to || n != 10) begin n_bad++; $display("FAIL first_shift got %0d cycles (timeout %0d) want 10", n, to); end
    n_cmp++; if (lives !== 2'd2 || level !== 3'd0) begin n_bad++; $display("FAIL start_status got lives %0d level %0d want 2 0", lives, level); end
    step();
    n_cmp++; if (road.load0_OutLow !== 1'b0 || road.load1_OutLow !== 1'b1) begin
      n_bad++; $display("FAIL shift1_load got load0 %b load1 %b want 0 1", road.load0_OutLow, road.load1_OutLow); end
  endtask

  task automatic test_scroll();
    int n; bit to; int exp_int; int exp_lvl; bit want1;
    for (int k = 2; k <= 17; k++) begin
      exp_int = (k <= 4) ? 13 : (k <= 8) ? 11 : (k <= 12) ? 9 : 7;
      exp_lvl = ((k - 1) / 4 > 3) ? 3 : (k - 1) / 4;
      want1   = (k % 3 == 0);
      wait_shift(30, n, to);
      n_cmp++; if (to || n + 1 != exp_int) begin n_bad++; $display("FAIL interval_shift%0d got %0d want %0d", k, n + 1, exp_int); end
      n_cmp++; if (level !== 3'(exp_lvl)) begin n_bad++; $display("FAIL level_shift%0d got %0d want %0d", k, level, exp_lvl); end
      step();
      n_cmp++; if (road.load1_OutLow !== !want1 || road.load0_OutLow !== want1) begin
        n_bad++; $display("FAIL load_shift%0d got load0 %b load1 %b want %b %b", k, road.load0_OutLow, road.load1_OutLow, want1, !want1); end
    end
    step(); step();
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL load_protocol got %0d violations want 0", viol); end
  endtask

  task automatic test_hit();
    int n; bit to; int act;
    reset_start();
    start_n = 1'b1; cmp_n = 1'b0;
    wait_shift(30, n, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL hit_first_shift got timeout want shift"); end
    step(); step(); step();
    n_cmp++; if (lives !== 2'd2 || !idle_now()) begin n_bad++; $display("FAIL hit_state got lives %0d idle %b want 2 1", lives, idle_now()); end
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (!idle_now() || lives !== 2'd1) begin n_bad++; $display("FAIL hit_wait%0d got idle %b lives %0d want 1 1", i, idle_now(), lives); end
    end
    step();
    n_cmp++; if (road.clear_OutLow !== 1'b0 || lives !== 2'd1 || level !== 3'd0) begin
      n_bad++; $display("FAIL recover_clear got clear %b lives %0d level %0d want 0 1 0", road.clear_OutLow, lives, level); end
    wait_shift(30, n, to);
    n_cmp++; if (to || n != 11) begin n_bad++; $display("FAIL recover_shift got %0d want 11", n); end
    step();
    n_cmp++; if (road.load0_OutLow !== 1'b0) begin n_bad++; $display("FAIL recover_load got load0 %b want 0", road.load0_OutLow); end
    step(); step(); step();
    n_cmp++; if (gameover !== 1'b1 || lives !== 2'd0) begin n_bad++; $display("FAIL gameover got go %b lives %0d want 1 0", gameover, lives); end
    act = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!idle_now() || gameover !== 1'b1) act++;
    end
    n_cmp++; if (act != 0) begin n_bad++; $display("FAIL gameover_quiet got %0d active cycles want 0", act); end
    start_n = 1'b0; step();
    n_cmp++; if (road.clear_OutLow !== 1'b0 || lives !== 2'd2 || level !== 3'd0 || gameover !== 1'b0) begin
      n_bad++; $display("FAIL restart got clear %b lives %0d level %0d go %b want 0 2 0 0", road.clear_OutLow, lives, level, gameover); end
    start_n = 1'b1; cmp_n = 1'b1;
  endtask

  task automatic test_pause();
    int n; bit to; int act; int clears; int shift_at;
    reset_start();
    repeat (7) step();
    pause_n = 1'b0;
    act = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 0) pause_n = 1'b1;
      if (!idle_now()) act++;
    end
    n_cmp++; if (act != 0) begin n_bad++; $display("FAIL pause_hold got %0d active cycles want 0", act); end
    pause_n = 1'b0;
    wait_shift(30, n, to);
    pause_n = 1'b1;
    n_cmp++; if (to || n != 5) begin n_bad++; $display("FAIL pause_resume got %0d want 5", n); end
    clears = 0; shift_at = 0;
    for (int i = 1; i <= 13; i++) begin
      step();
      if (!road.clear_OutLow) clears++;
      if (road.shiftselection_Out == 2'b01 && shift_at == 0) shift_at = i;
    end
    n_cmp++; if (clears != 0) begin n_bad++; $display("FAIL held_start got %0d clears want 0", clears); end
    n_cmp++; if (shift_at != 13) begin n_bad++; $display("FAIL post_pause_interval got %0d want 13", shift_at); end
  endtask

  task automatic test_async_reset();
    int n; bit to; int act;
    reset_start();
    start_n = 1'b1;
    wait_shift(30, n, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL areset_shift got timeout want shift"); end
    rst = 1'b1; #1;
    n_cmp++; if (road.shiftselection_Out !== 2'b11 || !idle_now()) begin
      n_bad++; $display("FAIL areset_in_shift got shift %b want 11", road.shiftselection_Out); end
    step(); rst = 1'b0;
    act = 0;
    for (int i = 0; i < 15; i++) begin step(); if (!idle_now() || gameover) act++; end
    n_cmp++; if (act != 0) begin n_bad++; $display("FAIL areset_idle1 got %0d active cycles want 0", act); end
    start_n = 1'b0; step(); start_n = 1'b1; cmp_n = 1'b0;
    wait_shift(30, n, to);
    step(); step(); step(); step();
    n_cmp++; if (to || lives !== 2'd1) begin n_bad++; $display("FAIL areset_hitwait_setup got lives %0d want 1", lives); end
    rst = 1'b1; #1;
    n_cmp++; if (lives !== 2'd2 || !idle_now() || level !== 3'd0) begin
      n_bad++; $display("FAIL areset_in_hitwait got lives %0d idle %b want 2 1", lives, idle_now()); end
    step(); rst = 1'b0; cmp_n = 1'b1;
    act = 0;
    for (int i = 0; i < 15; i++) begin step(); if (!idle_now() || gameover) act++; end
    n_cmp++; if (act != 0) begin n_bad++; $display("FAIL areset_idle2 got %0d active cycles want 0", act); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_scroll();
    test_hit();
    test_pause();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
